multi_key_click_ctrl: RTL and testbench
=======================================

Name: multi_key_click_ctrl

Overview:
- Parametrised N-key click classifier for board push-buttons.
- Per key: synchronises and debounces the input, then classifies each gesture as single click, double click or long press, with optional auto-repeat while a long press is held.
- Emits one-cycle pulses per key and per class.
- Also queues events into a single valid/ready event stream with round-robin arbitration, for LED/demo logic or a CPU-side register block.

Parameters:
- N_KEYS, 4: number of independent key channels (1..16).
- ACTIVE_LOW, 1: 1 = key reads 0 when pressed.
- DEBOUNCE_CYC, 500_000: debounce window in clocks (10 ms at 50 MHz).
- DCLICK_GAP_CYC, 5_000_000: maximum release-to-second-press gap for a double click.
- LONG_CYC, 150_000_000: hold time in HELD that yields a long press.
- REPEAT_EN, 0: 1 = emit repeat pulses while a long press is held.
- REPEAT_CYC, 10_000_000: repeat period.

Ports:
- CLOCK  in  1  single system clock.
- RESET  in  1  synchronous, active-high reset.
- KEY  in  N_KEYS  raw asynchronous key inputs.
- SCLICK  out  N_KEYS  1-cycle single-click pulse per key.
- DCLICK  out  N_KEYS  1-cycle double-click pulse per key.
- LCLICK  out  N_KEYS  1-cycle long-press pulse per key.
- REPEAT  out  N_KEYS  1-cycle repeat pulse per key.
- PRESSED  out  N_KEYS  debounced level, 1 = pressed.
- EVT_VALID  out  1  event stream valid.
- EVT_READY  in  1  event stream ready.
- EVT_KEY  out  clog2(N_KEYS) max 1  key index of the presented event.
- EVT_CODE  out  2  event class: 0 single, 1 double, 2 long, 3 repeat.
- OVERFLOW  out  N_KEYS  sticky flag: a pending event was overwritten.

Behaviour:
- Reset: all outputs 0; sync flops preset to the idle level; all channels to IDLE; counters, pending slots and the round-robin pointer cleared.
- Sync: two flops per key, then polarity normalisation gives k (1 = pressed). Edges are taken from k versus its registered copy. Input-to-edge latency is 3 clocks.
- Per-channel FSM, one counter C, every wait counts 0..X-1:
  - IDLE: on press edge -> DB_P1, C=0.
  - DB_P1: after DEBOUNCE_CYC, k=1 -> HELD, else IDLE (glitch rejected, no event).
  - HELD: on release edge -> DB_R1. When C = LONG_CYC-1 -> pulse LCLICK, go LONG.
  - LONG: if REPEAT_EN, pulse REPEAT every REPEAT_CYC (first pulse REPEAT_CYC after the LCLICK). On release -> DB_REND.
  - DB_R1: after DEBOUNCE_CYC -> GAP.
  - GAP: on press edge before C = DCLICK_GAP_CYC-1 -> DB_P2. At timeout pulse SCLICK -> IDLE.
  - DB_P2: after DEBOUNCE_CYC, k=1 -> pulse DCLICK, go WAIT_R; else pulse SCLICK -> IDLE.
  - WAIT_R: on release -> DB_REND. No long press is classified on a second press.
  - DB_REND: after DEBOUNCE_CYC -> IDLE.
- Edges arriving during any DB_* state are ignored.
- PRESSED is 1 in HELD, LONG, WAIT_R and DB_P2 after debounce confirms; 0 otherwise.
- Pulses are registered and last exactly 1 cycle. At most one class pulses per key per cycle.
- Counter width: clog2 of the max of all cycle parameters.
- Event queue:
  - Each channel has a 1-deep pending slot (code), written on any pulse.
  - A write to a full slot not being popped that cycle replaces the code and sets OVERFLOW[k]. OVERFLOW clears only on RESET.
  - Arbiter: when EVT_VALID=0 or the current event is popped, select the next pending channel round-robin, starting after the last granted index.
  - EVT_KEY, EVT_CODE and EVT_VALID are registered, and stable while VALID=1 and READY=0.
  - Pop occurs when VALID and READY are both 1.
  - Pop and a new write to the same slot in the same cycle: the slot holds the new code and no overflow is flagged.
  - Back-to-back pops are allowed, one event per cycle.
- RESET mid-gesture: returns to IDLE immediately; no pulse for the partial gesture.

Decomposition:
- Package key_click_pkg: FSM state enum; EVT_CODE constants (EVT_SINGLE=0, EVT_DOUBLE=1, EVT_LONG=2, EVT_REPEAT=3); a clog2 helper.
- Sub-module key_click_chan: sync, debounce, FSM and counter for one key, generated N_KEYS times.
- The top level holds the pending slots and the arbiter.

Test Plan:
- Sim params: N_KEYS=3, DEBOUNCE_CYC=4, DCLICK_GAP_CYC=20, LONG_CYC=50, REPEAT_EN=1, REPEAT_CYC=10.
- Single click: key0 pressed 15 clks, released -> one SCLICK[0] after the 20-clk gap times out; event {key0, 0}.
- Double click: key1 pressed 10, released 8, pressed 10 -> DCLICK[1] once, no SCLICK; event {key1, 1}.
- Long press with repeat: key2 held 100 clks -> LCLICK[2] ~50 clks after debounce, then REPEAT[2] every 10 clks (4 pulses); none after release.
- Glitch: 2-clk low pulse on key0 -> no pulses, PRESSED stays 0, stream idle.
- Back-pressure: EVT_READY=0 while three keys single-click simultaneously -> events present keys 0, 1, 2 in order once READY=1; a second click on key0 before the pop sets OVERFLOW[0].
- Reset mid-hold: RESET at clk 30 of a long press -> all outputs 0 next cycle; no LCLICK afterwards.

Source files
------------

// File: rtl/key_click_pkg.sv
// Shared types and helpers for the multi-key click classifier.
package key_click_pkg;

    // Per-channel gesture state
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DB_P1,
        ST_HELD,
        ST_LONG,
        ST_DB_R1,
        ST_GAP,
        ST_DB_P2,
        ST_WAIT_R,
        ST_DB_REND
    } chan_state_e;

    // Event stream class codes
    localparam logic [1:0] EVT_SINGLE = 2'd0;
    localparam logic [1:0] EVT_DOUBLE = 2'd1;
    localparam logic [1:0] EVT_LONG   = 2'd2;
    localparam logic [1:0] EVT_REPEAT = 2'd3;

    // Ceiling log2 for elaboration-time widths; clog2(1) = 0
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 62; i++)
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/key_click_chan.sv
// One key channel: 2-flop sync, edge detect, debounce and gesture FSM.
module key_click_chan
    import key_click_pkg::*;
#(
    parameter int ACTIVE_LOW     = 1,
    parameter int DEBOUNCE_CYC   = 500_000,
    parameter int DCLICK_GAP_CYC = 5_000_000,
    parameter int LONG_CYC       = 150_000_000,
    parameter int REPEAT_EN      = 0,
    parameter int REPEAT_CYC     = 10_000_000
) (
    input  logic gclk,
    input  logic rst,
    input  logic key,
    output logic sclick,
    output logic dclick,
    output logic lclick,
    output logic rpt,
    output logic pressed
);

    localparam int MAX_AB  = (DEBOUNCE_CYC > DCLICK_GAP_CYC) ? DEBOUNCE_CYC : DCLICK_GAP_CYC;
    localparam int MAX_CD  = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = (clog2(MAX_CYC) > 0) ? clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] DB_END   = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(DCLICK_GAP_CYC - 1);
    localparam logic [CW-1:0] LONG_END = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] REP_END  = CW'(REPEAT_CYC - 1);

    // Released level of the raw pin; sync flops start here so reset never fakes an edge
    localparam logic IDLE_LVL = (ACTIVE_LOW != 0);

    logic [1:0]    sync_q;
    logic          k;
    logic          k_q;
    logic          press_edge;
    logic          release_edge;
    chan_state_e   state;
    logic [CW-1:0] cnt;

    assign k            = sync_q[1] ^ IDLE_LVL;
    assign press_edge   = k & ~k_q;
    assign release_edge = ~k & k_q;

    // Synchroniser shift register plus registered copy of the normalised level
    always_ff @(posedge gclk) begin
        if (rst) begin
            sync_q <= {2{IDLE_LVL}};
            k_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], key};
            k_q    <= k;
        end
    end

    // Gesture FSM with a single shared wait counter and registered pulse/level outputs
    always_ff @(posedge gclk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            sclick  <= 1'b0;
            dclick  <= 1'b0;
            lclick  <= 1'b0;
            rpt     <= 1'b0;
            pressed <= 1'b0;
        end else begin
            sclick <= 1'b0;
            dclick <= 1'b0;
            lclick <= 1'b0;
            rpt    <= 1'b0;
            cnt    <= cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (press_edge) state <= ST_DB_P1;
                end
                ST_DB_P1: begin
                    if (cnt == DB_END) begin
                        cnt <= '0;
                        if (k) begin
                            state   <= ST_HELD;
                            pressed <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_HELD: begin
                    if (release_edge) begin
                        state   <= ST_DB_R1;
                        cnt     <= '0;
                        pressed <= 1'b0;
                    end else if (cnt == LONG_END) begin
                        state  <= ST_LONG;
                        cnt    <= '0;
                        lclick <= 1'b1;
                    end
                end
                ST_LONG: begin
                    if (release_edge) begin
                        state   <= ST_DB_REND;
                        cnt     <= '0;
                        pressed <= 1'b0;
                    end else if (REPEAT_EN == 0) begin
                        cnt <= '0;
                    end else if (cnt == REP_END) begin
                        cnt <= '0;
                        rpt <= 1'b1;
                    end
                end
                ST_DB_R1: begin
                    if (cnt == DB_END) begin
                        state <= ST_GAP;
                        cnt   <= '0;
                    end
                end
                ST_GAP: begin
                    // Timeout on the last gap cycle wins over a coincident press
                    if (cnt == GAP_END) begin
                        state  <= ST_IDLE;
                        cnt    <= '0;
                        sclick <= 1'b1;
                    end else if (press_edge) begin
                        state <= ST_DB_P2;
                        cnt   <= '0;
                    end
                end
                ST_DB_P2: begin
                    if (cnt == DB_END) begin
                        cnt <= '0;
                        if (k) begin
                            state   <= ST_WAIT_R;
                            dclick  <= 1'b1;
                            pressed <= 1'b1;
                        end else begin
                            state  <= ST_IDLE;
                            sclick <= 1'b1;
                        end
                    end
                end
                ST_WAIT_R: begin
                    cnt <= '0;
                    if (release_edge) begin
                        state   <= ST_DB_REND;
                        pressed <= 1'b0;
                    end
                end
                ST_DB_REND: begin
                    if (cnt == DB_END) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    cnt     <= '0;
                    pressed <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/multi_key_click_ctrl.sv
// N-key click classifier: per-key channels, 1-deep pending slots, round-robin event stream.
module multi_key_click_ctrl
    import key_click_pkg::*;
#(
    parameter int N_KEYS         = 4,
    parameter int ACTIVE_LOW     = 1,
    parameter int DEBOUNCE_CYC   = 500_000,
    parameter int DCLICK_GAP_CYC = 5_000_000,
    parameter int LONG_CYC       = 150_000_000,
    parameter int REPEAT_EN      = 0,
    parameter int REPEAT_CYC     = 10_000_000,
    localparam int KW            = (clog2(N_KEYS) > 0) ? clog2(N_KEYS) : 1
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] SCLICK,
    output logic [N_KEYS-1:0] DCLICK,
    output logic [N_KEYS-1:0] LCLICK,
    output logic [N_KEYS-1:0] REPEAT,
    output logic [N_KEYS-1:0] PRESSED,
    output logic              EVT_VALID,
    input  logic              EVT_READY,
    output logic [KW-1:0]     EVT_KEY,
    output logic [1:0]        EVT_CODE,
    output logic [N_KEYS-1:0] OVERFLOW
);

    logic [N_KEYS-1:0]       wr_vec;
    logic [N_KEYS-1:0][1:0]  wr_code;
    logic [N_KEYS-1:0]       pend_vld;
    logic [N_KEYS-1:0][1:0]  pend_code;
    logic [N_KEYS-1:0]       cur_oh;
    logic [N_KEYS-1:0]       avail;
    logic                    pop;
    logic [KW-1:0]           rr_ptr;
    logic                    grant_found;
    logic [KW-1:0]           grant_idx;
    int                      idx;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        key_click_chan #(
            .ACTIVE_LOW     (ACTIVE_LOW),
            .DEBOUNCE_CYC   (DEBOUNCE_CYC),
            .DCLICK_GAP_CYC (DCLICK_GAP_CYC),
            .LONG_CYC       (LONG_CYC),
            .REPEAT_EN      (REPEAT_EN),
            .REPEAT_CYC     (REPEAT_CYC)
        ) u_chan (
            .gclk    (CLOCK),
            .rst     (RESET),
            .key     (KEY[i]),
            .sclick  (SCLICK[i]),
            .dclick  (DCLICK[i]),
            .lclick  (LCLICK[i]),
            .rpt     (REPEAT[i]),
            .pressed (PRESSED[i])
        );

        assign wr_vec[i]  = SCLICK[i] | DCLICK[i] | LCLICK[i] | REPEAT[i];
        assign wr_code[i] = DCLICK[i] ? EVT_DOUBLE :
                            LCLICK[i] ? EVT_LONG   :
                            REPEAT[i] ? EVT_REPEAT : EVT_SINGLE;
    end

    assign pop = EVT_VALID & EVT_READY;

    // One-hot of the slot currently presented; it stays full until popped and is skipped by the arbiter
    always_comb begin
        for (int i = 0; i < N_KEYS; i++)
            cur_oh[i] = EVT_VALID && (EVT_KEY == KW'(i));
    end

    assign avail = pend_vld & ~cur_oh;

    // Round-robin pick of the first available slot at or after rr_ptr
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int i = 0; i < N_KEYS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_KEYS) idx = idx - N_KEYS;
            if (!grant_found && avail[idx]) begin
                grant_found = 1'b1;
                grant_idx   = KW'(idx);
            end
        end
    end

    // Pending slots: write wins over pop; overwrite of an unpopped full slot is flagged sticky
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            pend_vld  <= '0;
            pend_code <= '0;
            OVERFLOW  <= '0;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (wr_vec[i]) begin
                    pend_vld[i]  <= 1'b1;
                    pend_code[i] <= wr_code[i];
                    if (pend_vld[i] && !(pop && cur_oh[i])) OVERFLOW[i] <= 1'b1;
                end else if (pop && cur_oh[i]) begin
                    pend_vld[i] <= 1'b0;
                end
            end
        end
    end

    // Output register: reload when empty or popped, hold steady under back-pressure
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            EVT_VALID <= 1'b0;
            EVT_KEY   <= '0;
            EVT_CODE  <= '0;
            rr_ptr    <= '0;
        end else if (!EVT_VALID || pop) begin
            EVT_VALID <= grant_found;
            if (grant_found) begin
                EVT_KEY  <= grant_idx;
                EVT_CODE <= pend_code[grant_idx];
                rr_ptr   <= (grant_idx == KW'(N_KEYS - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multi_key_click_ctrl.sv
// Scoreboard bench: stimulus pushes expected pulses/events, a negedge monitor pops and compares.
module tb_multi_key_click_ctrl;

    localparam int N = 3;

    logic         CLOCK = 1'b0;
    logic         RESET = 1'b1;
    logic [N-1:0] KEY = '1;
    logic [N-1:0] SCLICK, DCLICK, LCLICK, REPEAT, PRESSED, OVERFLOW;
    logic         EVT_VALID;
    logic         EVT_READY = 1'b1;
    logic [1:0]   EVT_KEY;
    logic [1:0]   EVT_CODE;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;
    int t0     = 0;

    typedef struct {int key; int cls; int cyc;} pulse_t;
    typedef struct {int key; int code;} evt_t;

    pulse_t pq[$];
    evt_t   eq[$];
    pulse_t mon_p;
    evt_t   mon_e;
    logic [3:0] mon_bits;

    multi_key_click_ctrl #(
        .N_KEYS         (N),
        .ACTIVE_LOW     (1),
        .DEBOUNCE_CYC   (4),
        .DCLICK_GAP_CYC (20),
        .LONG_CYC       (50),
        .REPEAT_EN      (1),
        .REPEAT_CYC     (10)
    ) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .KEY       (KEY),
        .SCLICK    (SCLICK),
        .DCLICK    (DCLICK),
        .LCLICK    (LCLICK),
        .REPEAT    (REPEAT),
        .PRESSED   (PRESSED),
        .EVT_VALID (EVT_VALID),
        .EVT_READY (EVT_READY),
        .EVT_KEY   (EVT_KEY),
        .EVT_CODE  (EVT_CODE),
        .OVERFLOW  (OVERFLOW)
    );

    always #5 CLOCK = ~CLOCK;
    always @(posedge CLOCK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_pulse(input int k, input int c, input int t);
        pq.push_back('{key: k, cls: c, cyc: t});
    endtask

    task automatic push_evt(input int k, input int c);
        eq.push_back('{key: k, code: c});
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    // Monitor: every pulse (class 0..3 = single/double/long/repeat) and every pop is scored
    always @(negedge CLOCK) begin
        if (!RESET) begin
            for (int k = 0; k < N; k++) begin
                mon_bits = {REPEAT[k], LCLICK[k], DCLICK[k], SCLICK[k]};
                for (int c = 0; c < 4; c++) begin
                    if (mon_bits[c]) begin
                        if (pq.size() == 0) begin
                            check("unexpected_pulse(key*4+class)", k * 4 + c, -1);
                        end else begin
                            mon_p = pq.pop_front();
                            check("pulse_key", k, mon_p.key);
                            check("pulse_class", c, mon_p.cls);
                            check("pulse_cycle", cyc, mon_p.cyc);
                        end
                    end
                end
            end
            if (EVT_VALID && EVT_READY) begin
                if (eq.size() == 0) begin
                    check("unexpected_event(key*4+code)", int'(EVT_KEY) * 4 + int'(EVT_CODE), -1);
                end else begin
                    mon_e = eq.pop_front();
                    check("evt_key", int'(EVT_KEY), mon_e.key);
                    check("evt_code", int'(EVT_CODE), mon_e.code);
                end
            end
        end
    end

    initial begin
        // Reset state
        wait_cyc(3);
        check("rst_pulses", int'({SCLICK, DCLICK, LCLICK, REPEAT}), 0);
        check("rst_pressed", int'(PRESSED), 0);
        check("rst_evt_valid", int'(EVT_VALID), 0);
        check("rst_overflow", int'(OVERFLOW), 0);
        RESET = 1'b0;
        wait_cyc(5);

        // Single click on key0: 15-clk press, SCLICK once the 20-clk gap expires
        t0 = cyc;
        KEY[0] = 1'b0;
        push_pulse(0, 0, t0 + 42);
        push_evt(0, 0);
        wait_cyc(15);
        KEY[0] = 1'b1;
        wait_cyc(50);

        // Double click on key1: press 10, release 8, press 10
        t0 = cyc;
        KEY[1] = 1'b0;
        push_pulse(1, 1, t0 + 25);
        push_evt(1, 1);
        wait_cyc(10);
        KEY[1] = 1'b1;
        wait_cyc(8);
        KEY[1] = 1'b0;
        wait_cyc(10);
        KEY[1] = 1'b1;
        wait_cyc(40);

        // Long press with repeat on key2: held 100 clks, LCLICK then 4 REPEATs
        t0 = cyc;
        KEY[2] = 1'b0;
        push_pulse(2, 2, t0 + 57);
        push_evt(2, 2);
        for (int m = 1; m <= 4; m++) begin
            push_pulse(2, 3, t0 + 57 + 10 * m);
            push_evt(2, 3);
        end
        wait_cyc(30);
        check("long_pressed", int'(PRESSED[2]), 1);
        wait_cyc(70);
        KEY[2] = 1'b1;
        wait_cyc(10);
        check("long_released", int'(PRESSED[2]), 0);
        wait_cyc(20);

        // Glitch: 2-clk press on key0 is rejected
        KEY[0] = 1'b0;
        wait_cyc(2);
        KEY[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            wait_cyc(1);
            check("glitch_pressed", int'(PRESSED[0]), 0);
            check("glitch_evt_valid", int'(EVT_VALID), 0);
        end
        wait_cyc(10);

        // Back-pressure: all three keys click together with READY low
        EVT_READY = 1'b0;
        t0 = cyc;
        KEY = '0;
        push_pulse(0, 0, t0 + 42);
        push_pulse(1, 0, t0 + 42);
        push_pulse(2, 0, t0 + 42);
        wait_cyc(15);
        KEY = '1;
        wait_cyc(35);
        check("bp_valid", int'(EVT_VALID), 1);
        check("bp_key", int'(EVT_KEY), 0);
        check("bp_code", int'(EVT_CODE), 0);
        check("bp_overflow_clear", int'(OVERFLOW), 0);
        // Second click on key0 while its event is still presented
        KEY[0] = 1'b0;
        push_pulse(0, 0, t0 + 92);
        wait_cyc(15);
        KEY[0] = 1'b1;
        wait_cyc(31);
        check("bp_overflow_set", int'(OVERFLOW), 1);
        check("bp_key_stable", int'(EVT_KEY), 0);
        check("bp_valid_stable", int'(EVT_VALID), 1);
        push_evt(0, 0);
        push_evt(1, 0);
        push_evt(2, 0);
        EVT_READY = 1'b1;
        wait_cyc(10);
        check("bp_drained", int'(EVT_VALID), 0);
        check("bp_overflow_sticky", int'(OVERFLOW), 1);

        // Reset in the middle of a hold on key0
        t0 = cyc;
        KEY[0] = 1'b0;
        wait_cyc(30);
        check("rh_pressed_before", int'(PRESSED[0]), 1);
        RESET = 1'b1;
        wait_cyc(1);
        check("rh_pressed", int'(PRESSED), 0);
        check("rh_pulses", int'({SCLICK, DCLICK, LCLICK, REPEAT}), 0);
        check("rh_overflow", int'(OVERFLOW), 0);
        check("rh_evt_valid", int'(EVT_VALID), 0);
        RESET = 1'b0;
        KEY[0] = 1'b1;
        wait_cyc(80);
        check("rh_pressed_after", int'(PRESSED[0]), 0);

        check("pulse_queue_empty", pq.size(), 0);
        check("evt_queue_empty", eq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
